// File: rtl/lsu_data_ram_pkg.sv
// Shared constants and helpers for the load/store data RAM: funct3 codes,
// request decode (byte enables + error), store-lane replication and load extension.
package lsu_data_ram_pkg;

   localparam int XLEN  = 32;
   localparam int LANES = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic             err;
      logic [LANES-1:0] be;
   } dec_t;

   // Byte enables are only meaningful for legal stores; loads and errors get none.
   function automatic dec_t decode(input logic we, input logic [2:0] f3, input logic [1:0] ofs);
      dec_t d;
      d.err = 1'b0;
      d.be  = '0;
      case (f3)
         F3_B:    d.be = LANES'(1) << ofs;
         F3_H: begin
            d.err = ofs[0];
            d.be  = ofs[1] ? LANES'(4'b1100) : LANES'(4'b0011);
         end
         F3_W: begin
            d.err = |ofs;
            d.be  = '1;
         end
         F3_BU:   d.err = we;
         F3_HU:   d.err = we | ofs[0];
         default: d.err = 1'b1;
      endcase
      if (!we || d.err) d.be = '0;
      return d;
   endfunction

   function automatic logic [XLEN-1:0] replicate(input logic [2:0] f3, input logic [XLEN-1:0] wd);
      logic [XLEN-1:0] r;
      case (f3)
         F3_B:    r = {4{wd[7:0]}};
         F3_H:    r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [1:0] ofs,
                                              input logic [XLEN-1:0] word);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] r;
      b = 8'(word >> {ofs, 3'b000});
      h = ofs[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_W:    r = word;
         F3_BU:   r = {24'd0, b};
         F3_HU:   r = {16'd0, h};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_data_ram_if.sv
// Request/response bundle between the MEM stage (master) and the data RAM (slave).
interface lsu_data_ram_if #(parameter int ADDR_BITS = 12);
   import lsu_data_ram_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [2:0]           req_funct3;
   logic [ADDR_BITS-1:0] req_addr;
   logic [XLEN-1:0]      req_wdata;
   logic                 rsp_valid;
   logic [XLEN-1:0]      rsp_rdata;
   logic                 rsp_err;
   logic                 init_busy;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );
endinterface

// File: rtl/lsu_data_ram_bytewise.sv
// Word-wide single-port array with per-byte write enables and a registered read port.
// No reset on the array or read register so it maps onto block RAM.
module ram_bytewise
   import lsu_data_ram_pkg::*;
#(
   parameter int WA = 10
) (
   input  logic             clk,
   input  logic [WA-1:0]    addr,
   input  logic [LANES-1:0] we,
   input  logic [XLEN-1:0]  wdata,
   input  logic             re,
   output logic [XLEN-1:0]  rdata
);

   logic [XLEN-1:0] mem [2**WA];

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/lsu_data_ram.sv
// Byte-addressable load/store data memory with post-reset zero fill.
//  state   | meaning
//  ST_INIT | zero-filling word[fill_idx], requests blocked
//  ST_RUN  | accepting one request per cycle
module lsu_data_ram
   import lsu_data_ram_pkg::*;
#(
   parameter int ADDR_BITS      = 12,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic          clk,
   input logic          rst,
   lsu_data_ram_if.slave bus
);

   localparam int WA = ADDR_BITS - 2;

   state_t           state, state_nxt;
   logic [WA-1:0]    fill_idx;
   logic             fill_en;
   logic             fill_last;
   logic             accept;
   dec_t             dec;
   logic [WA-1:0]    ram_addr;
   logic [LANES-1:0] ram_we;
   logic [XLEN-1:0]  ram_wdata;
   logic             ram_re;
   logic [XLEN-1:0]  ram_q;

   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic             rsp_load_q;
   logic [2:0]       rsp_f3_q;
   logic [1:0]       rsp_ofs_q;

   assign fill_last = &fill_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
         fill_idx <= '0;
      end else begin
         state <= state_nxt;
         if (fill_en) fill_idx <= fill_idx + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      fill_en   = 1'b0;
      case (state)
         ST_INIT: begin
            fill_en = 1'b1;
            if (fill_last) state_nxt = ST_RUN;
         end
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
   end

   // rst gates ready combinationally so the skip-fill variant also shows ready=0 in reset.
   assign bus.req_ready = (state == ST_RUN) && !rst;
   assign bus.init_busy = (state == ST_INIT);
   assign accept        = bus.req_valid && bus.req_ready;
   assign dec           = decode(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

   always_comb begin
      ram_addr  = bus.req_addr[ADDR_BITS-1:2];
      ram_we    = accept ? dec.be : '0;
      ram_wdata = replicate(bus.req_funct3, bus.req_wdata);
      ram_re    = accept && !bus.req_we && !dec.err;
      if (fill_en) begin
         ram_addr  = fill_idx;
         ram_we    = '1;
         ram_wdata = '0;
         ram_re    = 1'b0;
      end
   end

   ram_bytewise #(.WA(WA)) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .re    (ram_re),
      .rdata (ram_q)
   );

   // Response qualifiers update only on accept so rdata/err hold between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_f3_q    <= '0;
         rsp_ofs_q   <= '0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_err_q  <= dec.err;
            rsp_load_q <= !bus.req_we && !dec.err;
            rsp_f3_q   <= bus.req_funct3;
            rsp_ofs_q  <= bus.req_addr[1:0];
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_load_q ? extend(rsp_f3_q, rsp_ofs_q, ram_q) : '0;

endmodule
